fifo_rd_stream: RTL and testbench

Read-side streaming engine for the FIFO. Runs in the read clock domain: watches the FIFO `empty` flag, issues `r_en` pops, and absorbs the one-cycle read latency of the FIFO storage in a 2-entry skid buffer. It presents the words on a valid/ready stream that sustains one word per cycle. It is the consumer end of the FIFO, mirroring the writer that fills it.

---
 rtl/fifo_rd_stream.sv | 155 +++++++++++++++
 tb/tb_fifo_rd_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side streaming engine for the FIFO, clocked by the FIFO read clock.
// It watches fifo_empty and issues fifo_r_en pops. A 2-entry skid buffer
// absorbs the one-cycle read latency of the FIFO storage. The words are
// presented on a valid/ready stream that can move one word per cycle.
//
// Parameters
//   DW        : data word width
//   BURST_LEN : words per burst for m_last framing (1..65535)
//
// Ports
//   r_clk        in  : read clock (FIFO read clock)
//   rst          in  : synchronous active-high reset
//   enable       in  : allow new pops; buffered/in-flight words always drain
//   fifo_empty   in  : FIFO empty flag (r_clk domain)
//   fifo_r_en    out : pop strobe (combinational)
//   fifo_rd_data in  : FIFO read data, valid the cycle after fifo_r_en
//   m_valid      out : output word valid
//   m_ready      in  : downstream accept
//   m_data       out : output word
//   busy         out : a word is in flight or buffered
//   m_last       out : last word of a burst (only with FIFO_RD_LAST_EN)
//
// Optional feature macro: FIFO_RD_LAST_EN adds m_last and a 16-bit burst
// counter. The default build has neither.
module fifo_rd_stream #(
  parameter int DW        = 8,
  parameter int BURST_LEN = 16
) (
  input  logic          r_clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          fifo_empty,
  output logic          fifo_r_en,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          busy
`ifdef FIFO_RD_LAST_EN
  ,
  output logic          m_last
`endif
);

  // The state encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    BUF0 = 2'd0,
    BUF1 = 2'd1,
    BUF2 = 2'd2
  } buf_state_e;

  buf_state_e    state;
  logic          in_flight;
  logic [DW-1:0] skid_p1;
  logic          xfer;
  logic          valid_nxt;
  logic [1:0]    occ;
  logic [1:0]    occ_left;

  // A BURST_LEN outside 1..65535 leaves this block elaborated as a marker.
  if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_burst_len_out_of_range
  end

  assign xfer     = m_valid && m_ready;
  // occ never exceeds 2. A transfer only happens with at least one word buffered.
  assign occ      = 2'(state) + {1'b0, in_flight};
  assign occ_left = occ - {1'b0, xfer};

  // Stage p0: pop issue. This path is combinational so that pops can
  // continue back to back at one word per cycle.
  assign fifo_r_en = !rst && enable && !fifo_empty && (occ_left < 2'd2);
  assign busy      = in_flight || m_valid;

  always_comb begin
    valid_nxt = 1'b0;
    case (state)
      BUF0:    valid_nxt = in_flight;
      BUF1:    valid_nxt = in_flight || !xfer;
      BUF2:    valid_nxt = 1'b1;
      default: valid_nxt = 1'b0;
    endcase
  end

  // Stage p1: landing of the popped word into head (m_data) or skid.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      state     <= BUF0;
      in_flight <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      in_flight <= fifo_r_en;
      m_valid   <= valid_nxt;
      case (state)
        BUF0: begin
          if (in_flight) begin
            m_data <= fifo_rd_data;
            state  <= BUF1;
          end
        end
        BUF1: begin
          if (in_flight && xfer) begin
            // The head leaves and the arriving word takes its slot.
            m_data <= fifo_rd_data;
          end else if (in_flight) begin
            skid_p1 <= fifo_rd_data;
            state   <= BUF2;
          end else if (xfer) begin
            state <= BUF0;
          end
        end
        BUF2: begin
          if (xfer) begin
            // The older skid word moves to the head before the new arrival, so order is kept.
            m_data <= skid_p1;
            if (in_flight) begin
              skid_p1 <= fifo_rd_data;
            end else begin
              state <= BUF1;
            end
          end
        end
        default: state <= BUF0;
      endcase
    end
  end

`ifdef FIFO_RD_LAST_EN
  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  logic [15:0] burst_cnt;
  logic [15:0] cnt_nxt;

  always_comb begin
    cnt_nxt = burst_cnt;
    if (xfer) begin
      cnt_nxt = (burst_cnt == LAST_IDX) ? 16'd0 : burst_cnt + 16'd1;
    end
  end

  // Stage p1: m_last comes from the transfer count of the word presented.
  // It follows the head word and does not depend on when that word was popped.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      burst_cnt <= 16'd0;
      m_last    <= 1'b0;
    end else begin
      burst_cnt <= cnt_nxt;
      m_last    <= valid_nxt && (cnt_nxt == LAST_IDX);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic       r_clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_r_en;
  logic [7:0] fifo_rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       busy;
  logic       m_last;

  always #5 r_clk = ~r_clk;

  fifo_rd_stream #(.DW(8), .BURST_LEN(4)) dut (
    .r_clk        (r_clk),
    .rst          (rst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_r_en    (fifo_r_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .busy         (busy)
`ifdef FIFO_RD_LAST_EN
    ,
    .m_last       (m_last)
`endif
  );

`ifndef FIFO_RD_LAST_EN
  assign m_last = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // FIFO model and output capture
  logic [7:0] q[$];
  logic [7:0] outq[$];
  logic       lastq[$];
  int         xcyc[$];
  int         cyc  = 0;
  int         pops = 0;

  logic       s_ren, s_vld, s_xfer, s_last, s_rst;
  logic [7:0] s_data;
  logic       hold_chk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_obs();
    outq.delete();
    lastq.delete();
    xcyc.delete();
    pops = 0;
  endtask

  // One clock cycle: sample at negedge, then model the FIFO pop after posedge.
  task automatic tick();
    @(negedge r_clk);
    cyc++;
    if (hold_chk && !s_rst) begin
      chk("hold_data", 32'(m_data), 32'(s_data));
`ifdef FIFO_RD_LAST_EN
      chk("hold_last", 32'(m_last), 32'(s_last));
`endif
    end
    s_ren    = fifo_r_en;
    s_vld    = m_valid;
    s_xfer   = m_valid && m_ready;
    s_data   = m_data;
    s_last   = m_last;
    s_rst    = rst;
    hold_chk = m_valid && !m_ready && !rst;
    @(posedge r_clk);
    #1;
    if (s_ren) begin
      pops++;
      chk("pop_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) fifo_rd_data = q.pop_front();
    end
    if (s_xfer && !s_rst) begin
      outq.push_back(s_data);
      lastq.push_back(s_last);
      xcyc.push_back(cyc);
    end
    fifo_empty = (q.size() == 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_pop, first_vld, sent;
    logic [7:0] exp_q[$];

    rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    fifo_empty = 1'b1; fifo_rd_data = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
    tick();
    chk("rst_no_pop", 32'(s_ren), 0);

    // Test 1: latency and back-to-back delivery
    rst = 1'b0;
    clear_obs();
    first_pop = -1; first_vld = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_ren && first_pop < 0) first_pop = cyc;
      if (s_vld && first_vld < 0) first_vld = cyc;
    end
    chk("t1_latency", 32'(first_vld - first_pop), 2);
    chk("t1_count", outq.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_word", 32'(outq[i]), 32'(8'h11 + i));
    chk("t1_back2back", 32'(xcyc[3] - xcyc[0]), 3);
    chk("t1_pops", pops, 4);
    chk("t1_busy_end", 32'(busy), 0);

    // Test 2: stalled output takes only two words
    clear_obs();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    repeat (10) tick();
    chk("t2_pops", pops, 2);
    chk("t2_valid", 32'(m_valid), 1);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_no_xfer", outq.size(), 0);
    chk("t2_fifo_left", q.size(), 6);
    m_ready = 1'b1;
    for (int i = 0; i < 40 && outq.size() < 8; i++) tick();
    chk("t2_count", outq.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_word", 32'(outq[i]), 32'(8'h20 + i));

    // Test 3: random backpressure and random refill
    clear_obs();
    sent = 0;
    for (int i = 0; i < 4000 && outq.size() < 200; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (sent < 200 && $urandom_range(0, 1) == 1) begin
        push(8'(sent) ^ 8'h5A);
        exp_q.push_back(8'(sent) ^ 8'h5A);
        sent++;
      end
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();
    chk("t3_count", outq.size(), 200);
    for (int i = 0; i < 200; i++) chk("t3_word", 32'(outq[i]), 32'(exp_q[i]));

    // Test 4: enable falls right after a pop issues
    clear_obs();
    m_ready = 1'b1; enable = 1'b1;
    push(8'h55); push(8'h56);
    tick();
    chk("t4_pop", 32'(s_ren), 1);
    enable = 1'b0;
    repeat (8) tick();
    chk("t4_no_more_pops", pops, 1);
    chk("t4_count", outq.size(), 1);
    chk("t4_word", 32'(outq[0]), 32'h55);
    enable = 1'b1;
    repeat (6) tick();
    chk("t4_resume_count", outq.size(), 2);
    chk("t4_resume_word", 32'(outq[1]), 32'h56);

    // Restart the burst count from zero
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

`ifdef FIFO_RD_LAST_EN
    // Test 5: m_last framing with BURST_LEN=4 under stalls
    clear_obs();
    for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 80 && outq.size() < 10; i++) begin
      m_ready = (i % 3 != 1);
      tick();
    end
    m_ready = 1'b1;
    chk("t5_count", outq.size(), 10);
    for (int k = 0; k < 10; k++) begin
      chk("t5_word", 32'(outq[k]), 32'(8'h30 + k));
      chk("t5_last", 32'(lastq[k]), 32'(k == 3 || k == 7));
    end
`endif

    // Test 6: reset while a pop is in flight
    clear_obs();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h61 + i));
    repeat (4) tick();
    chk("t6_pops", pops, 2);
    chk("t6_valid", 32'(m_valid), 1);
    m_ready = 1'b1;
    tick();
    chk("t6_pop_in_buf2", 32'(s_ren), 1);
    chk("t6_busy", 32'(busy), 1);
    rst = 1'b1; m_ready = 1'b0;
    q.delete(); fifo_empty = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(m_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    clear_obs();
    push(8'h71); push(8'h72);
    m_ready = 1'b1;
    repeat (8) tick();
    chk("t6_count", outq.size(), 2);
    chk("t6_word0", 32'(outq[0]), 32'h71);
    chk("t6_word1", 32'(outq[1]), 32'h72);
    chk("t6_busy_end", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
